// File: rtl/dram_interleave_splitter.sv
// Burst splitter: cuts one request into per-channel sub-bursts at interleave boundaries, logs {chan,len,last} in order.
// First sub-burst valid 1 cycle after accept, 1 sub-burst/cycle; stalls on channel ready and on a full order FIFO.

module splitter_fifo #(
  parameter  int Width = 8,
  parameter  int Depth = 8,
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld_i,
  output logic             push_rdy_o,
  input  logic [Width-1:0] push_dat_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [Width-1:0] pop_dat_o
);
  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [PtrW:0]    r_cnt;
  logic             w_full, w_empty, w_push, w_pop;

  assign w_full     = (r_cnt == (PtrW+1)'(Depth));
  assign w_empty    = (r_cnt == '0);
  assign w_pop      = pop_rdy_i && !w_empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign w_push     = push_vld_i && (!w_full || w_pop);
  assign push_rdy_o = !w_full;
  assign pop_vld_o  = !w_empty;
  assign pop_dat_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(Depth-1)) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(Depth-1)) ? '0 : r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (PtrW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_dat_i;
  end
endmodule

module dram_interleave_splitter #(
  parameter  int AddrWidth   = 32,
  parameter  int NumChannels = 4,
  parameter  int BeatBytes   = 64,
  parameter  int LenWidth    = 8,
  parameter  int MaxIlvLog2  = 7,
  parameter  int OrderDepth  = 8,
  localparam int ChanBits    = (NumChannels == 1) ? 0 : $clog2(NumChannels),
  localparam int ChW         = (ChanBits == 0) ? 1 : ChanBits,
  localparam int IlvW        = $clog2(MaxIlvLog2 + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IlvW-1:0]        cfg_ilv_log2_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [LenWidth-1:0]    req_len_i,
  input  logic                   req_write_i,
  output logic [NumChannels-1:0] chan_valid_o,
  input  logic [NumChannels-1:0] chan_ready_i,
  output logic [AddrWidth-1:0]   chan_addr_o,
  output logic [LenWidth-1:0]    chan_len_o,
  output logic                   chan_write_o,
  output logic                   chan_last_o,
  output logic                   ord_valid_o,
  input  logic                   ord_ready_i,
  output logic [ChW-1:0]         ord_chan_o,
  output logic [LenWidth-1:0]    ord_len_o,
  output logic                   ord_last_o,
  output logic                   busy_o
);
  localparam int BeatOff = $clog2(BeatBytes);
  localparam int RemW    = LenWidth + 1;
  localparam int TbW     = MaxIlvLog2 + 1;
  localparam int CW      = (RemW > TbW) ? RemW : TbW;
  localparam int OrdW    = ChW + LenWidth + 1;
  localparam int ShW     = $clog2(AddrWidth + BeatOff + MaxIlvLog2 + ChanBits + 1) + 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [AddrWidth-1:0] r_addr;
  logic [RemW-1:0]      r_rem;
  logic                 r_write;
  logic [IlvW-1:0]      r_ilv;

  logic [IlvW-1:0]      w_ilv_clamp;
  logic [ShW-1:0]       w_c;
  logic [AddrWidth-1:0] w_low_mask, w_hi, w_local;
  logic [ChW-1:0]       w_ch;
  logic [CW-1:0]        w_off, w_tb, w_rem, w_sub;
  logic                 w_last, w_split, w_fifo_rdy, w_fire;
  logic                 w_ord_vld;
  logic [OrdW-1:0]      w_ord_dat;

  assign w_ilv_clamp = (cfg_ilv_log2_i > IlvW'(MaxIlvLog2)) ? IlvW'(MaxIlvLog2) : cfg_ilv_log2_i;

  // Channel bits sit just above the granule; squeeze them out to form the channel-local address.
  assign w_c        = ShW'(BeatOff) + ShW'(r_ilv);
  assign w_low_mask = (AddrWidth'(1) << w_c) - AddrWidth'(1);
  assign w_hi       = r_addr >> (w_c + ShW'(ChanBits));
  assign w_local    = (w_hi << w_c) | (r_addr & w_low_mask);

  generate
    if (ChanBits == 0) begin : g_one_chan
      assign w_ch = '0;
    end else begin : g_multi_chan
      assign w_ch = ChW'(r_addr >> w_c);
    end
  endgenerate

  assign w_off   = CW'((r_addr >> BeatOff) & ((AddrWidth'(1) << r_ilv) - AddrWidth'(1)));
  assign w_tb    = (CW'(1) << r_ilv) - w_off;
  assign w_rem   = CW'(r_rem);
  assign w_sub   = (w_rem < w_tb) ? w_rem : w_tb;
  assign w_last  = (w_sub == w_rem);
  assign w_split = (r_state == SPLIT);
  assign w_fire  = w_split && w_fifo_rdy && chan_ready_i[w_ch];

  assign req_ready_o  = (r_state == IDLE);
  assign chan_valid_o = (w_split && w_fifo_rdy) ? (NumChannels'(1) << w_ch) : '0;
  assign chan_addr_o  = w_split ? w_local : '0;
  assign chan_len_o   = w_split ? LenWidth'(w_sub - CW'(1)) : '0;
  assign chan_write_o = w_split && r_write;
  assign chan_last_o  = w_split && w_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_nxt = SPLIT;
      SPLIT:   if (w_fire && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_write <= 1'b0;
      r_ilv   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && req_valid_i) begin
        r_addr  <= req_addr_i & ~AddrWidth'(BeatBytes - 1);
        r_rem   <= RemW'(req_len_i) + RemW'(1);
        r_write <= req_write_i;
        r_ilv   <= w_ilv_clamp;
      end else if (w_fire) begin
        r_addr <= r_addr + (AddrWidth'(w_sub) << BeatOff);
        r_rem  <= r_rem - RemW'(w_sub);
      end
    end
  end

  splitter_fifo #(
    .Width (OrdW),
    .Depth (OrderDepth)
  ) u_ord_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_vld_i (w_fire),
    .push_rdy_o (w_fifo_rdy),
    .push_dat_i ({w_ch, chan_len_o, w_last}),
    .pop_vld_o  (w_ord_vld),
    .pop_rdy_i  (ord_ready_i),
    .pop_dat_o  (w_ord_dat)
  );

  assign ord_valid_o = w_ord_vld;
  assign {ord_chan_o, ord_len_o, ord_last_o} = w_ord_vld ? w_ord_dat : '0;
  assign busy_o = (r_state != IDLE) || w_ord_vld;
endmodule
